// File: rtl/sram_mem_ctrl_pkg.sv
// rtl/sram_mem_ctrl_pkg.sv - shared state encoding, widths and range helper for the SRAM controller
package sram_mem_ctrl_pkg;

    localparam int SRAM_AW_DEF = 20;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_DONE  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } state_t;

    // A byte address is covered when nothing above the SRAM word/byte bits is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_wait_counter.sv
// rtl/sram_mem_ctrl_wait_counter.sv - loadable down-counter with zero flag shared by read and write waits
module sram_wait_counter
    import sram_mem_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - word-request responder driving strobes for one asynchronous 32-bit SRAM
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int SRAM_AW    = SRAM_AW_DEF,
    parameter int READ_WAIT  = 0,
    parameter int WRITE_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic               mem_is_write,
    output logic [31:0]        mem_rdata,
    output logic               mem_busy,
    output logic               bus_err,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [31:0]        sram_dq_i,
    output logic [31:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rd_reg;
    logic               rng_q;
    logic               req_in_range;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;

    assign req_in_range = addr_in_range(mem_addr, SRAM_AW);

    sram_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Request fields are captured on every IDLE edge; outside IDLE they hold the accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_reg  <= '0;
            rng_q   <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus_err <= (state == ST_IDLE) && !req_in_range;
            if (state == ST_IDLE) begin
                addr_q <= mem_addr[SRAM_AW+1:2];
                rng_q  <= req_in_range;
                if (mem_is_write) begin
                    wdata_q <= mem_wdata;
                end
            end
            if (state == ST_RD_WAIT) begin
                rd_reg <= sram_dq_i;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_is_write) begin
                    if (req_in_range) begin
                        state_nxt = ST_WR_SETUP;
                    end
                end else if (READ_WAIT > 0) begin
                    state_nxt    = ST_RD_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = RD_LOAD;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    state_nxt = ST_RD_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_WR_SETUP: begin
                cnt_load     = 1'b1;
                cnt_load_val = WR_LOAD;
                state_nxt    = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_zero) begin
                    state_nxt = ST_WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The data bus is only driven in states that also hold oe_n high, so the two never overlap.
    always_comb begin
        sram_addr  = addr_q;
        sram_dq_o  = wdata_q;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        mem_busy   = 1'b1;
        mem_rdata  = '0;
        case (state)
            ST_IDLE: begin
                sram_addr = mem_addr[SRAM_AW+1:2];
                if (!mem_is_write) begin
                    sram_ce_n = 1'b0;
                    sram_oe_n = 1'b0;
                    if (READ_WAIT == 0) begin
                        mem_busy  = 1'b0;
                        mem_rdata = req_in_range ? sram_dq_i : 32'd0;
                    end
                end
            end
            ST_RD_WAIT: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            ST_RD_DONE: begin
                mem_busy  = 1'b0;
                mem_rdata = rng_q ? rd_reg : 32'd0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
            ST_WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_we_n  = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - scoreboard bench for sram_mem_ctrl with zero-wait and two-wait read instances
module tb_sram_mem_ctrl;

    localparam int AW = 20;
    localparam int WW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0]   addr_a, wdata_a, rdata_a, dqi_a, dqo_a;
    logic          wr_a, busy_a, berr_a, ce_a, oe_a, we_a, dqoe_a;
    logic [AW-1:0] saddr_a;
    logic [31:0]   addr_b, wdata_b, rdata_b, dqi_b, dqo_b;
    logic          wr_b, busy_b, berr_b, ce_b, oe_b, we_b, dqoe_b;
    logic [AW-1:0] saddr_b;

    sram_mem_ctrl #(.SRAM_AW(AW), .READ_WAIT(0), .WRITE_WAIT(WW)) u_dut_a (
        .clk(clk), .rst(rst), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_is_write(wr_a),
        .mem_rdata(rdata_a), .mem_busy(busy_a), .bus_err(berr_a), .sram_addr(saddr_a),
        .sram_dq_i(dqi_a), .sram_dq_o(dqo_a), .sram_dq_oe(dqoe_a),
        .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(we_a)
    );

    sram_mem_ctrl #(.SRAM_AW(AW), .READ_WAIT(2), .WRITE_WAIT(WW)) u_dut_b (
        .clk(clk), .rst(rst), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_is_write(wr_b),
        .mem_rdata(rdata_b), .mem_busy(busy_b), .bus_err(berr_b), .sram_addr(saddr_b),
        .sram_dq_i(dqi_b), .sram_dq_o(dqo_b), .sram_dq_oe(dqoe_b),
        .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(we_b)
    );

    // SRAM models: 256 words each, preloaded on the first falling edge
    logic [31:0]   mem_a [256];
    logic [31:0]   mem_b [256];
    bit            init_done = 1'b0;
    int            run = 0, pulses = 0, last_run = 0, writes = 0, unstable = 0, contention = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [31:0]   cap_data = '0;

    assign dqi_a = (!ce_a && !oe_a) ? mem_a[saddr_a[7:0]] : 32'hFFFF_FFFF;
    assign dqi_b = (!ce_b && !oe_b) ? mem_b[saddr_b[7:0]] : 32'hFFFF_FFFF;

    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] = 32'hA000_0000 | 32'(i);
                mem_b[i] = 32'hB000_0000 | 32'(i);
            end
            mem_a[0]    = 32'h0BAD_F00D;
            mem_a[8'h10] = 32'hDEAD_BEEF;
            mem_a[8'h24] = 32'h1111_1111;
            mem_b[0]    = 32'h0BAD_F00D;
            mem_b[8'h11] = 32'hCAFE_F00D;
            init_done = 1'b1;
        end
        if ((dqoe_a && !oe_a) || (dqoe_b && !oe_b)) contention++;
        if (!rst) begin
            run = 0;
        end else if (!ce_a && !we_a) begin
            if (run == 0) begin
                cap_addr = saddr_a;
                cap_data = dqo_a;
            end else if (saddr_a != cap_addr || dqo_a != cap_data) begin
                unstable++;
            end
            if (!dqoe_a) unstable++;
            run++;
        end else if (run != 0) begin
            pulses++;
            last_run = run;
            if (run == WW && !ce_a && dqoe_a) begin
                mem_a[cap_addr[7:0]] = cap_data;
                writes++;
            end
            run = 0;
        end
    end

    int n_chk = 0, n_pass = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    task automatic rd_a(input logic [31:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        addr_a = addr;
        wr_a   = 1'b0;
        exp_q.push_back(exp);
        @(negedge clk);
        chk("rd_a_busy", 32'(busy_a), 32'd0);
        chk("rd_a_data", rdata_a, exp_q.pop_front());
    endtask

    task automatic rd_b(input logic [31:0] addr, input logic [31:0] exp,
                        output int busy_n, output int berr_n);
        int k;
        busy_n = 0;
        berr_n = 0;
        @(negedge clk);
        k = 0;
        while (busy_b && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (k == 10) chk("rd_b_sync_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        addr_b = addr;
        exp_q.push_back(exp);
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (berr_b) berr_n++;
            if (!busy_b) break;
            busy_n++;
            k++;
        end
        if (k == 10) chk("rd_b_timeout", 32'd1, 32'd0);
        chk("rd_b_data", rdata_b, exp_q.pop_front());
    endtask

    task automatic wr_op(input logic [31:0] addr, input logic [31:0] data, output int busy_n);
        int k;
        @(posedge clk); #1;
        addr_a  = addr;
        wdata_a = data;
        wr_a    = 1'b1;
        @(negedge clk);
        busy_n = int'(busy_a);
        @(posedge clk); #1;
        wr_a   = 1'b0;
        addr_a = 32'h40;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (!busy_a) break;
            busy_n++;
            k++;
        end
        if (k == 20) chk("wr_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bn, en, k;
        rst = 1'b0;
        addr_a = 32'h40; wdata_a = '0; wr_a = 1'b0;
        addr_b = 32'h44; wdata_b = '0; wr_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we_a",   32'(we_a),   32'd1);
        chk("rst_dqoe_a", 32'(dqoe_a), 32'd0);
        chk("rst_ce_a",   32'(ce_a),   32'd0);
        chk("rst_oe_a",   32'(oe_a),   32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_berr_a", 32'(berr_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_we_b",   32'(we_b),   32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // zero-wait read
        @(posedge clk); #1;
        addr_a = 32'h40;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("rd0_sram_addr", 32'(saddr_a), 32'h10);
        chk("rd0_busy", 32'(busy_a), 32'd0);
        chk("rd0_data", rdata_a, exp_q.pop_front());

        // single write, then read back
        wr_op(32'h80, 32'h1234_5678, bn);
        chk("wr_busy_cycles", 32'(bn), 32'd5);
        chk("wr_pulse_len", 32'(last_run), 32'd2);
        chk("wr_count", 32'(writes), 32'd1);
        chk("wr_addr", 32'(cap_addr), 32'h20);
        chk("wr_data", cap_data, 32'h1234_5678);
        rd_a(32'h80, 32'h1234_5678);

        // write request toggled during the pulse is ignored
        @(posedge clk); #1;
        addr_a = 32'h84; wdata_a = 32'hA5A5_A5A5; wr_a = 1'b1;
        @(posedge clk); #1;
        wr_a = 1'b0;
        @(posedge clk); #1;
        addr_a = 32'h88; wdata_a = 32'h5A5A_5A5A; wr_a = 1'b1;
        @(posedge clk); #1;
        wr_a = 1'b0; addr_a = 32'h40;
        k = 0;
        while (busy_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("tog_count", 32'(writes), 32'd2);
        rd_a(32'h84, 32'hA5A5_A5A5);
        rd_a(32'h88, 32'hA000_0022);

        // multi-cycle reads on the READ_WAIT=2 instance
        rd_b(32'h44, 32'hCAFE_F00D, bn, en);
        chk("rdw_busy_cycles", 32'(bn), 32'd3);
        chk("rdw_berr", 32'(en), 32'd0);
        @(negedge clk);
        chk("rdw_back_idle", 32'(busy_b), 32'd1);
        rd_b(32'h0040_0000, 32'd0, bn, en);
        chk("rdw_oor_busy", 32'(bn), 32'd3);
        chk("rdw_oor_berr", 32'(en), 32'd1);

        // out-of-range write: dropped, single bus_err cycle
        k = pulses;
        @(posedge clk); #1;
        addr_a = 32'h0040_0000; wdata_a = 32'h7777_7777; wr_a = 1'b1;
        @(negedge clk);
        chk("oorw_busy", 32'(busy_a), 32'd1);
        chk("oorw_berr0", 32'(berr_a), 32'd0);
        @(posedge clk); #1;
        wr_a = 1'b0; addr_a = 32'h40;
        @(negedge clk);
        chk("oorw_berr1", 32'(berr_a), 32'd1);
        chk("oorw_idle", 32'(busy_a), 32'd0);
        @(negedge clk);
        chk("oorw_berr2", 32'(berr_a), 32'd0);
        chk("oorw_no_pulse", 32'(pulses), 32'(k));

        // out-of-range zero-wait read
        @(posedge clk); #1;
        addr_a = 32'h0040_0000;
        exp_q.push_back(32'd0);
        @(negedge clk);
        chk("oorr_data", rdata_a, exp_q.pop_front());
        @(posedge clk); #1;
        addr_a = 32'h40;
        @(negedge clk);
        chk("oorr_berr1", 32'(berr_a), 32'd1);
        @(negedge clk);
        chk("oorr_berr2", 32'(berr_a), 32'd0);

        // reset in the middle of the write pulse
        @(posedge clk); #1;
        addr_a = 32'h90; wdata_a = 32'h55AA_55AA; wr_a = 1'b1;
        @(posedge clk); #1;
        wr_a = 1'b0; addr_a = 32'h40;
        @(posedge clk); #1;
        chk("rstw_in_pulse", 32'(we_a), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstw_we", 32'(we_a), 32'd1);
        chk("rstw_dqoe", 32'(dqoe_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rd_a(32'h90, 32'h1111_1111);
        chk("rstw_count", 32'(writes), 32'd2);

        chk("no_contention", 32'(contention), 32'd0);
        chk("wr_stable", 32'(unstable), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Physical memory responder at the far end of the MMU's physical bus (dev_mem_addr / dev_mem_data_out / dev_mem_is_write in, dev_mem_data_in / dev_mem_busy out).
- Translates word requests into timed strobes for one external asynchronous 32-bit SRAM.
- Reads may be combinational (zero wait) or multi-cycle. Writes are always latched and multi-cycle.
- Busy rises before the next posedge whenever the current request cannot finish in the current cycle.

Parameters:
- SRAM_AW, 20, SRAM word-address width; covered byte range is 0 .. 2^(SRAM_AW+2)-1.
- READ_WAIT, 0, extra cycles per read; 0 means the read completes in the same cycle.
- WRITE_WAIT, 2, cycles the we_n pulse stays low; legal range is 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- mem_addr  in  32  physical byte address; bits [1:0] ignored
- mem_wdata  in  32  write data, sampled together with mem_addr at the accepting posedge
- mem_is_write  in  1  write request
- mem_rdata  out  32  read data
- mem_busy  out  1  request not yet complete
- bus_err  out  1  one-cycle pulse on an out-of-range access
- sram_addr  out  SRAM_AW  SRAM word address
- sram_dq_i  in  32  SRAM data bus, read side
- sram_dq_o  out  32  SRAM data bus, drive side
- sram_dq_oe  out  1  drive enable for sram_dq_o
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low

Behaviour:
- States: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD. A 4-bit down-counter cnt serves both wait phases.
- Reset (asynchronous): state=IDLE, cnt=0, all latches=0, bus_err=0, sram_we_n=1, sram_dq_oe=0.
  - Outputs during reset follow IDLE decode, with a read implied.
  - Reset during a write abandons it: we_n returns high immediately and the write must not complete.
- in_range = (mem_addr[31:SRAM_AW+2] == 0).
- IDLE with mem_is_write=0 (a read is always implied, since instruction fetch is continuous):
  - sram_addr = mem_addr[SRAM_AW+1:2], ce_n=0, oe_n=0, we_n=1, dq_oe=0.
  - READ_WAIT==0: mem_rdata = sram_dq_i combinationally, or 0 if !in_range. mem_busy=0. No state change.
  - READ_WAIT>0: mem_busy=1 combinationally. At the posedge, latch the address, load cnt=READ_WAIT-1, go to RD_WAIT.
- RD_WAIT: drive the latched address with oe_n=0; mem_busy=1. At the posedge, latch sram_dq_i into rd_reg. If cnt==0 go to RD_DONE, else decrement cnt.
- RD_DONE: mem_busy=0 and mem_rdata = rd_reg (0 if out of range). Always go to IDLE next. A new request is not accepted in RD_DONE.
- IDLE with mem_is_write=1:
  - mem_busy=1 combinationally.
  - At the posedge, latch the address and data, then go to WR_SETUP, or stay in IDLE if !in_range (write dropped).
- WR_SETUP: ce_n=0, oe_n=1, we_n=1, dq_oe=1, sram_dq_o = latched data. Load cnt=WRITE_WAIT-1, go to WR_PULSE.
- WR_PULSE: we_n=0. Decrement cnt; go to WR_HOLD when cnt==0.
- WR_HOLD: we_n=1, data still driven. Go to IDLE.
- mem_busy=1 in every WR_* state and in RD_WAIT.
- mem_is_write, mem_addr and mem_wdata are ignored outside IDLE.
- Write latency: the accept cycle plus WRITE_WAIT+2 cycles, all with busy=1. The first non-busy cycle is IDLE.
- Address, ce_n and dq_oe are stable throughout every WR_* state.
- bus_err pulses high for the cycle after any accepted out-of-range request (read or write). An out-of-range read returns 0 with normal latency.
- Bus-contention rule: dq_oe=1 implies oe_n=1, in every state and every cycle.

Decomposition:
- Shared header additions:
  - state encoding localparams, 3 bits;
  - SRAM_AW default;
  - in-range address macro.
- One natural sub-module, sram_wait_counter: a loadable 4-bit down-counter with a zero flag, reused for the read and write wait phases.

Test Plan:
- READ_WAIT=0, SRAM model word 0x0000_0010 = 0xDEADBEEF; mem_addr=0x40 -> same cycle: sram_addr=0x10, mem_rdata=0xDEADBEEF, mem_busy=0.
- WRITE_WAIT=2; write 0x12345678 to 0x80 for one cycle -> busy high that cycle plus 4 more; we_n low for exactly 2 cycles with addr 0x20 and data stable; a subsequent read of 0x80 returns 0x12345678.
- READ_WAIT=2; read 0x44 -> busy for 3 cycles, RD_DONE returns the model data with busy=0, then IDLE.
- Write to 0x0040_0000 (SRAM_AW=20) -> no we_n pulse, bus_err high for 1 cycle; a read there returns 0 with bus_err pulsed.
- Assert rst low in WR_PULSE -> we_n=1 and dq_oe=0 immediately; the model word is unchanged.
- mem_is_write toggled during WR_PULSE -> ignored; one write only.
- Checker in every test: dq_oe and !oe_n are never both high.
